// File: rtl/mlp_mac_sequencer.sv
// mlp_mac_sequencer: holds one input vector and N_NEURONS weight vectors and
// streams them, one inp/weight pair per cycle, into an external MAC_unit for
// each neuron in turn. The Sigmoid_unit result of every neuron is captured and
// presented as a valid-qualified output, and done pulses after the last neuron.
module mlp_mac_sequencer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned S1_NUM     = 4,
    parameter int unsigned N_NEURONS  = 2,
    localparam int unsigned AW = ($clog2(N_NEURONS * S1_NUM) > 0) ? $clog2(N_NEURONS * S1_NUM) : 1,
    localparam int unsigned IW = ($clog2(N_NEURONS) > 0) ? $clog2(N_NEURONS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] mac_inp,
    output logic [DATA_WIDTH-1:0] mac_weight,
    output logic                  mac_enable,
    output logic                  mac_clr,
    input  logic                  mac_rdy,
    input  logic [DATA_WIDTH-1:0] act_in,
    output logic                  out_valid,
    output logic [IW-1:0]         out_idx,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  done
);

    localparam int unsigned KW   = ($clog2(S1_NUM) > 0) ? $clog2(S1_NUM) : 1;
    localparam int unsigned NOPS = N_NEURONS * S1_NUM;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_FEED = 3'd2,
        S_WAIT = 3'd3,
        S_CAP  = 3'd4,
        S_FIN  = 3'd5
    } state_e;

    state_e state_q, state_d;
    logic [IW-1:0] n_q, n_d;
    logic [KW-1:0] k_q, k_d;

    // Operand storage: input vector and flattened weights (neuron*S1_NUM + k).
    logic [DATA_WIDTH-1:0] inp_q [S1_NUM];
    logic [DATA_WIDTH-1:0] inp_d [S1_NUM];
    logic [DATA_WIDTH-1:0] w_q   [NOPS];
    logic [DATA_WIDTH-1:0] w_d   [NOPS];

    // Registered outputs.
    logic                  busy_q,       busy_d;
    logic [DATA_WIDTH-1:0] mac_inp_q,    mac_inp_d;
    logic [DATA_WIDTH-1:0] mac_weight_q, mac_weight_d;
    logic                  mac_enable_q, mac_enable_d;
    logic                  mac_clr_q,    mac_clr_d;
    logic                  out_valid_q,  out_valid_d;
    logic [IW-1:0]         out_idx_q,    out_idx_d;
    logic [DATA_WIDTH-1:0] out_data_q,   out_data_d;
    logic                  done_q,       done_d;

    logic                  cap_en;
    logic [AW-1:0]         w_idx;

    // Next-state, counters and operand writes (writes only accepted in IDLE).
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        inp_d   = inp_q;
        w_d     = w_q;
        cap_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wr_en) begin
                    if (!wr_sel) begin
                        for (int unsigned i = 0; i < S1_NUM; i++) begin
                            if (wr_addr == AW'(i)) begin
                                inp_d[i] = wr_data;
                            end
                        end
                    end else begin
                        for (int unsigned i = 0; i < NOPS; i++) begin
                            if (wr_addr == AW'(i)) begin
                                w_d[i] = wr_data;
                            end
                        end
                    end
                end
                if (start) begin
                    state_d = S_CLR;
                    n_d     = '0;
                end
            end
            S_CLR: begin
                k_d     = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                if (k_q == KW'(S1_NUM - 1)) begin
                    state_d = S_WAIT;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_WAIT: begin
                if (mac_rdy) begin
                    state_d = S_CAP;
                    cap_en  = 1'b1;
                end
            end
            S_CAP: begin
                if (n_q == IW'(N_NEURONS - 1)) begin
                    state_d = S_FIN;
                end else begin
                    n_d     = n_q + IW'(1);
                    state_d = S_CLR;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so registered outputs line up with the state.
    always_comb begin
        busy_d       = (state_d != S_IDLE);
        mac_clr_d    = (state_d == S_CLR);
        mac_enable_d = (state_d == S_FEED);
        out_valid_d  = (state_d == S_CAP);
        done_d       = (state_d == S_FIN);
        w_idx        = AW'(n_d) * AW'(S1_NUM) + AW'(k_d);
        mac_inp_d    = '0;
        mac_weight_d = '0;
        out_idx_d    = out_idx_q;
        out_data_d   = out_data_q;

        if (state_d == S_FEED) begin
            mac_inp_d    = inp_q[k_d];
            mac_weight_d = w_q[w_idx];
        end
        // Activation is sampled while rdy is high, so it is valid during CAP.
        if (cap_en) begin
            out_data_d = act_in;
            out_idx_d  = n_q;
        end
    end

    // FSM state and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
        end
    end

    // Operand registers and registered outputs; reset clears everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < S1_NUM; i++) begin
                inp_q[i] <= '0;
            end
            for (int unsigned i = 0; i < NOPS; i++) begin
                w_q[i] <= '0;
            end
            busy_q       <= 1'b0;
            mac_inp_q    <= '0;
            mac_weight_q <= '0;
            mac_enable_q <= 1'b0;
            mac_clr_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            out_data_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            inp_q        <= inp_d;
            w_q          <= w_d;
            busy_q       <= busy_d;
            mac_inp_q    <= mac_inp_d;
            mac_weight_q <= mac_weight_d;
            mac_enable_q <= mac_enable_d;
            mac_clr_q    <= mac_clr_d;
            out_valid_q  <= out_valid_d;
            out_idx_q    <= out_idx_d;
            out_data_q   <= out_data_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign mac_inp    = mac_inp_q;
    assign mac_weight = mac_weight_q;
    assign mac_enable = mac_enable_q;
    assign mac_clr    = mac_clr_q;
    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign out_data   = out_data_q;
    assign done       = done_q;

endmodule

// File: tb/tb_mlp_mac_sequencer.sv
// Testbench for mlp_mac_sequencer: behavioural MAC/sigmoid model on the
// MAC side, a cycle table for the baseline pass, and directed corner cases.
module tb_mlp_mac_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en, wr_sel, start;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy, mac_enable, mac_clr, mac_rdy, out_valid, done;
    logic [7:0] mac_inp, mac_weight, act_in, out_data;
    logic [0:0] out_idx;

    int n_pass  = 0;
    int n_total = 0;

    mlp_mac_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .busy      (busy),
        .mac_inp   (mac_inp),
        .mac_weight(mac_weight),
        .mac_enable(mac_enable),
        .mac_clr   (mac_clr),
        .mac_rdy   (mac_rdy),
        .act_in    (act_in),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .done      (done)
    );

    always #5 clk = ~clk;

    // MAC_unit + Sigmoid_unit model: rdy after 4 accumulations since the last clear.
    int   m_acc, m_cnt;
    logic rdy_hold  = 1'b0;
    logic rdy_force = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_acc <= 0;
            m_cnt <= 0;
        end else if (mac_clr) begin
            m_acc <= 0;
            m_cnt <= 0;
        end else if (mac_enable) begin
            m_acc <= m_acc + int'($signed(mac_inp)) * int'($signed(mac_weight));
            m_cnt <= m_cnt + 1;
        end
    end

    assign mac_rdy = ((m_cnt == 4) && !rdy_hold) || rdy_force;
    assign act_in  = (m_acc > 0) ? 8'd127 : ((m_acc < 0) ? 8'd0 : 8'd64);

    typedef struct packed {
        logic       busy;
        logic       clr;
        logic       en;
        logic [7:0] inp;
        logic [7:0] wt;
        logic       ov;
        logic       idx;
        logic [7:0] dat;
        logic       dn;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t row(input logic b, input logic c, input logic e,
                                 input logic [7:0] i, input logic [7:0] w,
                                 input logic v, input logic x,
                                 input logic [7:0] d, input logic n);
        vec_t r;
        r.busy = b; r.clr = c; r.en = e; r.inp = i; r.wt = w;
        r.ov = v; r.idx = x; r.dat = d; r.dn = n;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wr(input logic sel, input int addr, input int data);
        @(posedge clk);
        #1 wr_en = 1'b1; wr_sel = sel; wr_addr = 3'(addr); wr_data = 8'(data);
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic load_default();
        for (int i = 0; i < 4; i++) begin
            wr(1'b0, i, i + 1);
            wr(1'b1, i, i + 1);
            wr(1'b1, 4 + i, -(i + 1));
        end
    endtask

    // Results of the most recent run_pass.
    int         done_cyc, nvalid;
    int         vcyc [2];
    logic       vidx [2];
    logic [7:0] vdata [2];
    logic       en_in_wait, busy_bad, overlap;

    // One full pass; cycle 1 is the cycle after the one start is high in.
    task automatic run_pass(input int rel_cyc, input bit inject, input bit wr_with_start,
                            input bit force_rdy);
        int c;
        nvalid = 0; done_cyc = -1; en_in_wait = 1'b0; busy_bad = 1'b0; overlap = 1'b0;
        vcyc[0] = -1; vcyc[1] = -1;
        vdata[0] = 8'hxx; vdata[1] = 8'hxx;
        rdy_hold  = (rel_cyc > 0);
        rdy_force = force_rdy;
        @(posedge clk);
        #1 start = 1'b1;
        if (wr_with_start) begin
            wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 3'd4; wr_data = 8'd99;
        end
        @(posedge clk);
        #1 start = 1'b0; wr_en = 1'b0;
        c = 1;
        while (done_cyc < 0 && c <= 60) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (out_valid && done) overlap = 1'b1;
            if (out_valid === 1'b1 && nvalid < 2) begin
                vcyc[nvalid]  = c;
                vidx[nvalid]  = out_idx[0];
                vdata[nvalid] = out_data;
                nvalid++;
            end
            if (done === 1'b1) done_cyc = c;
            if (rel_cyc > 0 && c >= 6 && c <= rel_cyc && mac_enable !== 1'b0) en_in_wait = 1'b1;
            if (c == rel_cyc) rdy_hold = 1'b0;
            if (inject && c == 4) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 3'd4; wr_data = 8'd99;
            end
            if (inject && c == 5) begin
                start = 1'b0; wr_en = 1'b0;
            end
            c++;
        end
        rdy_hold  = 1'b0;
        rdy_force = 1'b0;
    endtask

    initial begin
        vec_t act;
        reset = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        #23;
        chk("reset_outputs",
            {busy, mac_inp, mac_weight, mac_enable, mac_clr, out_valid, out_idx, out_data, done},
            '0);
        @(negedge clk);
        reset = 1'b1;

        // Baseline pass checked cycle by cycle.
        tbl[0]  = row(1, 1, 0, 8'd0, 8'd0,   0, 0, 8'd0,   0);
        tbl[1]  = row(1, 0, 1, 8'd1, 8'd1,   0, 0, 8'd0,   0);
        tbl[2]  = row(1, 0, 1, 8'd2, 8'd2,   0, 0, 8'd0,   0);
        tbl[3]  = row(1, 0, 1, 8'd3, 8'd3,   0, 0, 8'd0,   0);
        tbl[4]  = row(1, 0, 1, 8'd4, 8'd4,   0, 0, 8'd0,   0);
        tbl[5]  = row(1, 0, 0, 8'd0, 8'd0,   0, 0, 8'd0,   0);
        tbl[6]  = row(1, 0, 0, 8'd0, 8'd0,   1, 0, 8'd127, 0);
        tbl[7]  = row(1, 1, 0, 8'd0, 8'd0,   0, 0, 8'd127, 0);
        tbl[8]  = row(1, 0, 1, 8'd1, 8'hFF,  0, 0, 8'd127, 0);
        tbl[9]  = row(1, 0, 1, 8'd2, 8'hFE,  0, 0, 8'd127, 0);
        tbl[10] = row(1, 0, 1, 8'd3, 8'hFD,  0, 0, 8'd127, 0);
        tbl[11] = row(1, 0, 1, 8'd4, 8'hFC,  0, 0, 8'd127, 0);
        tbl[12] = row(1, 0, 0, 8'd0, 8'd0,   0, 0, 8'd127, 0);
        tbl[13] = row(1, 0, 0, 8'd0, 8'd0,   1, 1, 8'd0,   0);
        tbl[14] = row(1, 0, 0, 8'd0, 8'd0,   0, 1, 8'd0,   1);
        tbl[15] = row(0, 0, 0, 8'd0, 8'd0,   0, 1, 8'd0,   0);

        load_default();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            act = row(busy, mac_clr, mac_enable, mac_inp, mac_weight,
                      out_valid, out_idx[0], out_data, done);
            chk($sformatf("cycle%0d", i + 1), 64'(act), 64'(tbl[i]));
        end

        // rdy held low 5 extra cycles in neuron 0 WAIT.
        run_pass(11, 0, 0, 0);
        chk("stall_done_cyc", done_cyc, 20);
        chk("stall_cap0_cyc", vcyc[0], 12);
        chk("stall_enable_low", en_in_wait, 0);
        chk("stall_data", {vdata[0], vdata[1]}, {8'd127, 8'd0});

        // Stale rdy through CLR/FEED must not shortcut FEED.
        run_pass(0, 0, 0, 1);
        chk("stale_cap0_cyc", vcyc[0], 7);
        chk("stale_done_cyc", done_cyc, 15);

        // start and a weight write while busy are both ignored.
        run_pass(0, 1, 0, 0);
        chk("inject_done_cyc", done_cyc, 15);
        chk("inject_data1", vdata[1], 8'd0);
        chk("inject_busy_overlap", {busy_bad, overlap}, 2'b00);
        run_pass(0, 0, 0, 0);
        chk("after_inject_data", {vidx[0], vdata[0], vidx[1], vdata[1]},
            {1'b0, 8'd127, 1'b1, 8'd0});
        chk("after_inject_done", done_cyc, 15);

        // Write on the start cycle is used by that pass (w1[0]=99 -> sum 70).
        run_pass(0, 0, 1, 0);
        chk("wr_with_start_data1", vdata[1], 8'd127);
        wr(1'b1, 4, -1);

        // Out-of-range input index is dropped (would make neuron 0 negative).
        wr(1'b0, 4, -128);
        run_pass(0, 0, 0, 0);
        chk("oor_write_data0", vdata[0], 8'd127);

        // Reset during neuron 1 FEED.
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c < 10; c++) @(negedge clk);
        chk("pre_reset_feed", {mac_enable, mac_weight}, {1'b1, 8'hFF});
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outputs",
            {busy, mac_inp, mac_weight, mac_enable, mac_clr, out_valid, out_idx, out_data, done},
            '0);
        @(negedge clk);
        reset = 1'b1;
        run_pass(0, 0, 0, 0);
        chk("post_reset_cleared", {vidx[0], vdata[0], vdata[1]}, {1'b0, 8'd64, 8'd64});
        chk("post_reset_done", done_cyc, 15);
        load_default();
        run_pass(0, 0, 0, 0);
        chk("reload_data", {vdata[0], vdata[1]}, {8'd127, 8'd0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mlp_mac_sequencer.md
Name: mlp_mac_sequencer

Overview:
- Upstream feeder for the neuron datapath (MAC_unit followed by Sigmoid_unit).
- Holds the input vector and per-neuron weight vectors in local registers.
- On start, streams one inp/weight pair per cycle into MAC_unit for each neuron in turn and waits for its rdy.
- Captures each Sigmoid_unit result and presents it as a valid-qualified output; one pass evaluates all N_NEURONS neurons.

Parameters:
DATA_WIDTH, 8, signed width of inputs, weights and activation
S1_NUM, 4, inputs per neuron (MAC accumulation length)
N_NEURONS, 2, neurons evaluated per pass
AW, $clog2(N_NEURONS*S1_NUM), write address width (localparam)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
wr_en  in  1  load strobe for operand registers
wr_sel  in  1  0 = input vector, 1 = weight memory
wr_addr  in  AW  input index (wr_sel=0) or neuron*S1_NUM+k (wr_sel=1)
wr_data  in  DATA_WIDTH  signed operand
start  in  1  begin a pass (single-cycle pulse)
busy  out  1  pass in progress
mac_inp  out  DATA_WIDTH  to MAC_unit.inp
mac_weight  out  DATA_WIDTH  to MAC_unit.weight
mac_enable  out  1  to MAC_unit.enable
mac_clr  out  1  active-high clear to MAC_unit.reset
mac_rdy  in  1  from MAC_unit.rdy
act_in  in  DATA_WIDTH  from Sigmoid_unit.out
out_valid  out  1  one-cycle pulse, out_data valid
out_idx  out  $clog2(N_NEURONS) (min 1)  neuron index of out_data
out_data  out  DATA_WIDTH  captured activation
done  out  1  one-cycle pulse after last neuron

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; operand registers 0; neuron counter n=0, element counter k=0.
- Writes: wr_en in IDLE writes wr_data to the selected register on the clock edge. Writes while busy=1 are ignored. Out-of-range wr_addr is ignored (input vector indices >= S1_NUM).
- start accepted only in IDLE; ignored while busy. Simultaneous wr_en and start in IDLE: the write takes effect, and the pass uses the new value.
- FSM states:
  - IDLE: busy=0. On start go to CLR, with n=0.
  - CLR: busy=1, mac_clr=1 for exactly one cycle, mac_enable=0, k=0. Go to FEED.
  - FEED: mac_enable=1, mac_inp=inp[k], mac_weight=w[n][k] (registered outputs), k increments each cycle. Lasts exactly S1_NUM cycles, then go to WAIT.
  - WAIT: mac_enable=0, mac_inp and mac_weight forced to 0. Stay until mac_rdy=1, then go to CAP.
  - CAP: out_data<=act_in, out_idx<=n, out_valid=1 for one cycle. If n==N_NEURONS-1, go to FIN; else increment n and go to CLR.
  - FIN: done=1 for one cycle, then go to IDLE.
- Latency: start at edge 0 puts CLR at cycle 1 and FEED at cycles 2..S1_NUM+1. With mac_rdy already high on entering WAIT, CAP is at cycle S1_NUM+3. Per neuron: S1_NUM+3 cycles plus rdy wait. Total for defaults: 2*(4+3)+1 = 15 cycles start-to-done.
- mac_rdy is ignored outside WAIT; a stale rdy seen during CLR or FEED has no effect.
- out_data holds its value until the next CAP. out_valid and done never overlap.
- Reset mid-pass: the pass is aborted immediately, all outputs return to reset values, and operand registers are cleared.
- No arithmetic performed locally; widths are passed through unchanged, with signed interpretation preserved.

Test Plan:
- Load inp={1,2,3,4}, w0={1,2,3,4}, w1={-1,-2,-3,-4}; pulse start with mac_rdy tied to a MAC model -> mac_clr at cycle 1; mac_inp 1,2,3,4 and mac_weight 1,2,3,4 on cycles 2..5; then mac_weight -1..-4 for neuron 1. MAC model sums are 30 and -30.
- Same load, act_in driven from model (sigmoid(30)->127, sigmoid(-30)->0) -> out_valid pulses with (out_idx=0, out_data=127) then (out_idx=1, out_data=0). done is exactly one cycle later than the second out_valid; busy is 1 from cycle 1 through the done cycle.
- mac_rdy held low 5 extra cycles in neuron 0 WAIT -> FSM stalls, mac_enable=0 throughout; done arrives 5 cycles later than the 15-cycle baseline.
- start pulsed and wr_en with wr_data=99 issued mid-pass -> no restart; second pass uses unchanged operands and yields identical out_data.
- reset driven low during FEED of neuron 1 -> all outputs 0 asynchronously (before next edge); after release, state is IDLE and start runs a full pass from n=0.
- mac_rdy high during CLR/FEED (stale) -> CAP occurs only after FEED completes, i.e. at cycle S1_NUM+3.
